demux_tdm_1x8: RTL and testbench

Serial-to-parallel time-division demultiplexer: the receiving end of the 8-channel TDM link built from the Mux_8x1 tree, where the transmitter scans its select lines 0..7 and emits one channel bit per slot. The block locks to a frame sync, steers each slot's bit into its channel register, and publishes all eight channels together once per frame. It sits between the serial link input and the parallel consumer logic.

---
 rtl/demux_tdm_pkg.sv | 14 +
 rtl/demux_slot_ctr.sv | 30 +++
 rtl/demux_tdm_1x8.sv | 150 +++++++++++++++
 tb/tb_demux_tdm_1x8.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_tdm_pkg.sv
// demux_tdm_pkg: shared types and constants for the 1x8 TDM demultiplexer.
// Optional feature macro: DEMUX_TDM_PARITY_EN (adds a trailing even-parity slot).
package demux_tdm_pkg;
  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  localparam int SLOT_W     = 4;
  localparam int DATA_SLOTS = 8;
  localparam int MISS_LIMIT = 2;
`ifdef DEMUX_TDM_PARITY_EN
  localparam int FRAME_LEN  = 9;  // 8 data slots + parity slot
`else
  localparam int FRAME_LEN  = 8;
`endif
endpackage

// File: rtl/demux_slot_ctr.sv
// demux_slot_ctr: slot index counter for the TDM demultiplexer.
// Ports:
//   clk, rst   clock, async active-high reset
//   clr        synchronous clear to slot 0 (highest priority)
//   load1      synchronous load to slot 1 (sync beat consumed as slot 0)
//   adv        advance one slot, wrapping after FRAME_LEN-1
//   slot       index of the next expected slot
//   last       slot is the final slot of the frame
module demux_slot_ctr
  import demux_tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load1,
  input  logic              adv,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  assign last = (slot == SLOT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        slot <= '0;
    else if (clr)   slot <= '0;
    else if (load1) slot <= SLOT_W'(1);
    else if (adv)   slot <= last ? '0 : slot + 1'b1;
  end

endmodule

// File: rtl/demux_tdm_1x8.sv
// demux_tdm_1x8: serial-to-parallel TDM demultiplexer, 8 channels per frame.
// Locks on a frame sync, steers each slot bit into a shadow register and
// publishes the whole frame on ch_out once complete.
// Optional feature macro: DEMUX_TDM_PARITY_EN -- frame gains a 9th slot with
// even parity over the data; a mismatching frame is dropped with parity_err.
// Ports:
//   clk, rst     clock, async active-high reset
//   din          serial data, sampled when en=1
//   en           slot strobe, one slot per clk with en=1
//   sync         frame marker for slot 0 (qualified by en)
//   ch_out       last complete frame, bit i = channel i
//   frame_valid  1-cycle pulse when ch_out updates
//   slot         index of the next expected slot
//   locked       high while in RUN
//   sync_err     1-cycle pulse on sync at a nonzero slot
//   parity_err   1-cycle pulse on parity mismatch (0 without parity)
module demux_tdm_1x8
  import demux_tdm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  en,
  input  logic                  sync,
  output logic [DATA_SLOTS-1:0] ch_out,
  output logic                  frame_valid,
  output logic [SLOT_W-1:0]     slot,
  output logic                  locked,
  output logic                  sync_err,
  output logic                  parity_err
);

  state_t                state;
  logic [1:0]            miss;
  logic [DATA_SLOTS-1:0] shadow;
  logic [DATA_SLOTS-1:0] frame_word;
  logic                  last;
  logic                  at_zero;
  logic                  data_slot;
  logic                  miss_out;
  logic                  ctr_clr, ctr_load1, ctr_adv;

  assign at_zero   = (slot == '0);
  assign data_slot = (slot < SLOT_W'(DATA_SLOTS));
  // Second consecutive sync-less slot 0 drops the lock.
  assign miss_out  = at_zero && (miss == 2'(MISS_LIMIT - 1));

  // Shadow with the current beat merged in; on the parity slot it is just
  // the shadow, which holds all 8 data bits by then.
  always_comb begin
    frame_word = shadow;
    if (data_slot) frame_word[slot[2:0]] = din;
  end

  always_comb begin
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_adv   = 1'b0;
    if (en) begin
      if (state == HUNT) ctr_load1 = sync;
      else if (sync)     ctr_load1 = 1'b1;  // any sync restarts at slot 1
      else if (miss_out) ctr_clr   = 1'b1;
      else               ctr_adv   = 1'b1;
    end
  end

  demux_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .adv   (ctr_adv),
    .slot  (slot),
    .last  (last)
  );

`ifdef DEMUX_TDM_PARITY_EN
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      miss         <= '0;
      shadow       <= '0;
      ch_out       <= '0;
      frame_valid  <= 1'b0;
      locked       <= 1'b0;
      sync_err     <= 1'b0;
`ifdef DEMUX_TDM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_valid  <= 1'b0;
      sync_err     <= 1'b0;
`ifdef DEMUX_TDM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (en) begin
        case (state)
          HUNT: begin
            if (sync) begin
              shadow[0] <= din;
              miss      <= '0;
              state     <= RUN;
              locked    <= 1'b1;
            end
          end
          RUN: begin
            if (sync) begin
              // Sync anywhere but slot 0 discards the partial frame; the
              // beat becomes slot 0 of a fresh frame either way.
              shadow[0] <= din;
              miss      <= '0;
              if (!at_zero) sync_err <= 1'b1;
            end else if (miss_out) begin
              miss   <= '0;
              state  <= HUNT;
              locked <= 1'b0;
            end else begin
              if (at_zero)   miss <= miss + 1'b1;
              if (data_slot) shadow[slot[2:0]] <= din;
              if (last) begin
`ifdef DEMUX_TDM_PARITY_EN
                if ((^shadow) == din) begin
                  ch_out      <= frame_word;
                  frame_valid <= 1'b1;
                end else begin
                  parity_err_q <= 1'b1;
                end
`else
                ch_out      <= frame_word;
                frame_valid <= 1'b1;
`endif
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_tdm_1x8.sv
// tb_demux_tdm_1x8: randomized + directed bench for demux_tdm_1x8, checked
// every cycle against a queue-based frame model. Honors DEMUX_TDM_PARITY_EN.
module tb_demux_tdm_1x8;

`ifdef DEMUX_TDM_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0, en = 1'b0, sync = 1'b0;
  logic [7:0] ch_out;
  logic       frame_valid, locked, sync_err, parity_err;
  logic [3:0] slot;

  demux_tdm_1x8 dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
    .ch_out(ch_out), .frame_valid(frame_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int fv_cnt = 0, serr_cnt = 0, perr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bits collected since the last sync in a queue.
  bit       m_locked;
  bit       q[$];
  int       m_miss;
  bit [7:0] m_ch;
  bit       m_fv, m_serr, m_perr;

  task automatic model_reset();
    m_locked = 0; q.delete(); m_miss = 0; m_ch = '0;
    m_fv = 0; m_serr = 0; m_perr = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit d);
    bit [7:0] w;
    m_fv = 0; m_serr = 0; m_perr = 0;
    if (!e) return;
    if (!m_locked) begin
      if (s) begin m_locked = 1; q.delete(); q.push_back(d); m_miss = 0; end
      return;
    end
    if (s) begin
      if (q.size() != 0) m_serr = 1;
      q.delete(); q.push_back(d); m_miss = 0;
      return;
    end
    if (q.size() == 0) begin
      m_miss++;
      if (m_miss >= 2) begin m_locked = 0; m_miss = 0; return; end
    end
    q.push_back(d);
    if (q.size() == L) begin
      for (int i = 0; i < 8; i++) w[i] = q[i];
      if (L == 9 && ((^w) != q[8])) m_perr = 1;
      else begin m_ch = w; m_fv = 1; end
      q.delete();
    end
  endtask

  task automatic compare_all();
    chk("ch_out",      32'(ch_out),      32'(m_ch));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("slot",        32'(slot),        m_locked ? 32'(q.size()) : 32'd0);
    chk("locked",      32'(locked),      32'(m_locked));
    chk("sync_err",    32'(sync_err),    32'(m_serr));
    chk("parity_err",  32'(parity_err),  32'(m_perr));
  endtask

  task automatic beat(input bit e, input bit s, input bit d);
    @(negedge clk); en = e; sync = s; din = d;
    @(posedge clk); model_step(e, s, d);
    #1;
    compare_all();
    if (frame_valid) fv_cnt++;
    if (sync_err)    serr_cnt++;
    if (parity_err)  perr_cnt++;
  endtask

  function automatic bit slot_bit(input logic [7:0] data, input int i, input bit bad_par);
    if (i < 8) return data[i];
    return (^data) ^ bad_par;
  endfunction

  // One frame; gaps inserts random en=0 cycles between beats.
  task automatic send_frame(input logic [7:0] data, input bit with_sync,
                            input bit bad_par, input bit gaps);
    for (int i = 0; i < L; i++) begin
      while (gaps && $urandom_range(2) == 0) beat(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      beat(1, with_sync && i == 0, slot_bit(data, i, bad_par));
    end
  endtask

  task automatic async_reset();
    @(negedge clk); en = 0; sync = 0;
    #2 rst = 1;
    #1 model_reset();
    compare_all();
    @(negedge clk); rst = 0;
  endtask

  int       fv0, s0, p0, tx_pos;
  logic [7:0] tx_data, cw;
  bit       e, s, d;

  initial begin
    model_reset();
    #3 compare_all();              // outputs held in reset
    @(negedge clk); rst = 0;

    // HUNT ignores beats without sync
    for (int i = 0; i < 3; i++) beat(1, 0, 1'($urandom_range(1)));

    // Lock with 0x55
    fv0 = fv_cnt;
    send_frame(8'h55, 1, 0, 0);
    chk("lock_ch_out", 32'(ch_out), 32'h55);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_fv_cnt", 32'(fv_cnt - fv0), 32'd1);

    // Same frame with en gaps
    fv0 = fv_cnt;
    send_frame(8'h55, 1, 0, 1);
    for (int i = 0; i < 3; i++) beat(0, 0, 0);
    chk("gap_ch_out", 32'(ch_out), 32'h55);
    chk("gap_fv_cnt", 32'(fv_cnt - fv0), 32'd1);

    // Misplaced sync at slot 5; offending bit becomes channel 0
    fv0 = fv_cnt; s0 = serr_cnt;
    cw = 8'hC3;
    for (int i = 0; i < 5; i++) beat(1, i == 0, cw[i]);
    beat(1, 1, 1'b0);
    chk("missync_serr", 32'(serr_cnt - s0), 32'd1);
    chk("missync_nofv", 32'(fv_cnt - fv0), 32'd0);
    chk("missync_slot", 32'(slot), 32'd1);
    cw = 8'h3C;                     // bit 0 = 0, matches the offending beat
    for (int i = 1; i < L; i++) beat(1, 0, slot_bit(cw, i, 0));
    chk("missync_ch_out", 32'(ch_out), 32'h3C);

    // Two frames without sync: first published, second drops lock
    fv0 = fv_cnt;
    send_frame(8'h96, 0, 0, 0);
    chk("nosync1_ch_out", 32'(ch_out), 32'h96);
    send_frame(8'h0F, 0, 0, 0);
    chk("nosync2_fv", 32'(fv_cnt - fv0), 32'd1);
    chk("nosync2_locked", 32'(locked), 32'd0);
    chk("nosync2_slot", 32'(slot), 32'd0);

`ifdef DEMUX_TDM_PARITY_EN
    fv0 = fv_cnt; p0 = perr_cnt;
    send_frame(8'hA5, 1, 0, 0);
    send_frame(8'hA5, 1, 1, 0);
    chk("par_fv_cnt", 32'(fv_cnt - fv0), 32'd1);
    chk("par_err_cnt", 32'(perr_cnt - p0), 32'd1);
    chk("par_ch_out", 32'(ch_out), 32'hA5);
`endif

    // Async reset at slot 4
    send_frame(8'h81, 1, 0, 0);
    for (int i = 0; i < 4; i++) beat(1, i == 0, 1'b1);
    fv0 = fv_cnt;
    async_reset();
    for (int i = 0; i < L + 2; i++) beat(1, 0, 1'b1);
    chk("rst_no_pulse", 32'(fv_cnt - fv0), 32'd0);

    // Randomized link traffic
    tx_pos = 0; tx_data = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(3) != 0);
      if (!e) begin
        beat(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end else begin
        if (tx_pos == 0) begin
          s = ($urandom_range(15) != 0);
          tx_data = 8'($urandom);
        end else begin
          s = ($urandom_range(63) == 0);
          if (s) begin tx_pos = 0; tx_data = 8'($urandom); end
        end
        d = slot_bit(tx_data, tx_pos, $urandom_range(7) == 0);
        beat(1, s, d);
        tx_pos = (tx_pos + 1) % L;
      end
      if (n == 1500) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
